// File: rtl/water_pkg.sv
// Shared types and constants for the water-level encoder slice.
package water_pkg;

  localparam int unsigned LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = 4'hF;

  typedef enum logic [1:0] {
    S_INIT,
    S_TRACK,
    S_FAULT
  } wl_state_t;

  typedef struct packed {
    logic [LEVEL_W-1:0] cand;
    logic               bubble;
  } decode_t;

endpackage

// File: rtl/water_level_encoder_therm_to_level.sv
// Combinational thermometer decoder: candidate level is the length of the wet run
// starting at probe 0; any wet probe above the first dry one marks a bubble.
module therm_to_level
  import water_pkg::*;
#(
  parameter int unsigned NPROBE = 15
) (
  input  logic [NPROBE-1:0] probe_i,
  output decode_t           dec_c
);

  always_comb begin
    logic run;
    dec_c = '0;
    run   = 1'b1;
    for (int unsigned i = 0; i < NPROBE; i++) begin
      if (probe_i[i] && run) begin
        dec_c.cand = LEVEL_W'(dec_c.cand + LEVEL_W'(1));
      end else if (probe_i[i]) begin
        dec_c.bubble = 1'b1;
      end
      if (!probe_i[i]) begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/water_level_encoder.sv
// Probe column to debounced 4-bit water level with change strobe and bubble fault.
// Optional LEVEL_HYST_EN: single-step level changes while tracking need twice the stable ticks.
module water_level_encoder
  import water_pkg::*;
#(
  parameter int unsigned NPROBE     = 15,
  parameter int unsigned SAMPLE_DIV = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NPROBE-1:0]  probe,
  output logic [LEVEL_W-1:0] water_level,
  output logic               level_valid,
  output logic               level_change,
  output logic               fault
);

  if (NPROBE < 1 || NPROBE > 15) begin : g_bad_nprobe
    $error("water_level_encoder: NPROBE must be 1..15");
  end
  if (SAMPLE_DIV < 1) begin : g_bad_div
    $error("water_level_encoder: SAMPLE_DIV must be >= 1");
  end
  if (STABLE_CNT < 1) begin : g_bad_stable
    $error("water_level_encoder: STABLE_CNT must be >= 1");
  end

`ifdef LEVEL_HYST_EN
  localparam int unsigned CNT_MAX = 2 * STABLE_CNT;
`else
  localparam int unsigned CNT_MAX = STABLE_CNT;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned LX_W  = LEVEL_W + 1;

  logic [NPROBE-1:0]  sync1_q, sync2_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  decode_t            prev_q, prev_d, dec_c;
  wl_state_t          state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               valid_q, valid_d;
  logic               change_q, change_d;
  logic               fault_q, fault_d;
  logic               tick_c, stable_c, track_ok_c;

  therm_to_level #(.NPROBE(NPROBE)) u_therm (
    .probe_i (sync2_q),
    .dec_c   (dec_c)
  );

  assign tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));

  // Divider and run-length counter of identical decoded samples
  always_comb begin
    div_d  = tick_c ? '0 : DIV_W'(div_q + DIV_W'(1));
    cnt_d  = cnt_q;
    prev_d = prev_q;
    if (tick_c) begin
      prev_d = dec_c;
      if (dec_c == prev_q) begin
        cnt_d = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : CNT_W'(cnt_q + CNT_W'(1));
      end else begin
        cnt_d = CNT_W'(1);
      end
    end
  end

  assign stable_c = (cnt_d >= CNT_W'(STABLE_CNT));

`ifdef LEVEL_HYST_EN
  logic [LX_W-1:0] cand_x, lvl_x;
  logic            near_c;
  assign cand_x     = {1'b0, dec_c.cand};
  assign lvl_x      = {1'b0, level_q};
  assign near_c     = (cand_x == LX_W'(lvl_x + LX_W'(1))) || (lvl_x == LX_W'(cand_x + LX_W'(1)));
  assign track_ok_c = near_c ? (cnt_d >= CNT_W'(2 * STABLE_CNT)) : stable_c;
`else
  assign track_ok_c = stable_c;
`endif

  // Level acceptance FSM, only advanced on sample ticks
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    fault_d  = fault_q;
    if (tick_c && stable_c) begin
      unique case (state_q)
        S_INIT: begin
          if (dec_c.bubble) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            level_d  = dec_c.cand;
            valid_d  = 1'b1;
            change_d = 1'b1;
            state_d  = S_TRACK;
          end
        end
        S_TRACK: begin
          if (dec_c.bubble) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else if (track_ok_c && (dec_c.cand != level_q)) begin
            level_d  = dec_c.cand;
            change_d = 1'b1;
          end
        end
        S_FAULT: begin
          if (!dec_c.bubble) begin
            fault_d  = 1'b0;
            level_d  = dec_c.cand;
            valid_d  = 1'b1;
            change_d = (dec_c.cand != level_q) || !valid_q;
            state_d  = S_TRACK;
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= probe;
      sync2_q <= sync1_q;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_INIT;
      level_q  <= LEVEL_FULL;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      fault_q  <= fault_d;
    end
  end

  assign water_level  = level_q;
  assign level_valid  = valid_q;
  assign level_change = change_q;
  assign fault        = fault_q;

endmodule
